// File: rtl/id_ex_stage_if.sv
// ============================================================================
// Module   : id_ex_stage_if
// Purpose  : Decode-side bus for the ID/EX stage (IF/ID inputs, RF port, EX regs)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface id_ex_stage_if;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        flush;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall_out;
  logic        ex_valid;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic [31:0] ex_imm;
  logic [31:0] ex_pc4;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_dst;
  logic [4:0]  ex_shamt;
  logic [2:0]  ex_alu_op;
  logic        ex_alu_src;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic        ex_branch;

  modport master (
    output if_valid, if_instr, if_pc4, flush, rs_data, rt_data,
    input  rs_addr, rt_addr, stall_out, ex_valid, ex_rs_data, ex_rt_data,
           ex_imm, ex_pc4, ex_rs, ex_rt, ex_dst, ex_shamt, ex_alu_op,
           ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_mem_to_reg, ex_branch
  );

  modport slave (
    input  if_valid, if_instr, if_pc4, flush, rs_data, rt_data,
    output rs_addr, rt_addr, stall_out, ex_valid, ex_rs_data, ex_rt_data,
           ex_imm, ex_pc4, ex_rs, ex_rt, ex_dst, ex_shamt, ex_alu_op,
           ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_mem_to_reg, ex_branch
  );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Purpose  : MIPS decode stage + ID/EX register with load-use stall and flush
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_stage (
  input  wire logic    clk,
  input  wire logic    reset,
  id_ex_stage_if.slave bus
);

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_SLTI  = 6'h0A;
  localparam logic [5:0] c_OP_ANDI  = 6'h0C;
  localparam logic [5:0] c_OP_ORI   = 6'h0D;
  localparam logic [5:0] c_OP_LUI   = 6'h0F;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;

  localparam logic [5:0] c_FN_ADD = 6'h20;
  localparam logic [5:0] c_FN_SUB = 6'h22;
  localparam logic [5:0] c_FN_AND = 6'h24;
  localparam logic [5:0] c_FN_OR  = 6'h25;
  localparam logic [5:0] c_FN_SLT = 6'h2A;
  localparam logic [5:0] c_FN_SLL = 6'h00;
  localparam logic [5:0] c_FN_SRL = 6'h02;

  localparam logic [2:0] c_ALU_ADD = 3'd0;
  localparam logic [2:0] c_ALU_SUB = 3'd1;
  localparam logic [2:0] c_ALU_AND = 3'd2;
  localparam logic [2:0] c_ALU_OR  = 3'd3;
  localparam logic [2:0] c_ALU_SLT = 3'd4;
  localparam logic [2:0] c_ALU_SLL = 3'd5;
  localparam logic [2:0] c_ALU_SRL = 3'd6;
  localparam logic [2:0] c_ALU_LUI = 3'd7;

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic        w_ok;
  logic [2:0]  w_alu_op;
  logic        w_alu_src;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_reg_write;
  logic        w_mem_to_reg;
  logic        w_branch;
  logic        w_zext;
  logic        w_uses_rs;
  logic        w_uses_rt;
  logic [4:0]  w_dst;
  logic [31:0] w_imm;
  logic        w_stall;
  logic        w_load;

  logic        r_valid;
  logic [31:0] r_rs_data;
  logic [31:0] r_rt_data;
  logic [31:0] r_imm;
  logic [31:0] r_pc4;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_dst;
  logic [4:0]  r_shamt;
  logic [2:0]  r_alu_op;
  logic        r_alu_src;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        r_reg_write;
  logic        r_mem_to_reg;
  logic        r_branch;

  assign w_opcode = bus.if_instr[31:26];
  assign w_funct  = bus.if_instr[5:0];
  assign w_rs     = bus.if_instr[25:21];
  assign w_rt     = bus.if_instr[20:16];

  always_comb begin
    w_ok         = 1'b1;
    w_alu_op     = c_ALU_ADD;
    w_alu_src    = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_branch     = 1'b0;
    w_zext       = 1'b0;
    w_uses_rs    = 1'b1;
    w_uses_rt    = 1'b0;
    w_dst        = w_rt;
    case (w_opcode)
      c_OP_RTYPE: begin
        w_dst       = bus.if_instr[15:11];
        w_reg_write = 1'b1;
        w_uses_rt   = 1'b1;
        case (w_funct)
          c_FN_ADD: w_alu_op = c_ALU_ADD;
          c_FN_SUB: w_alu_op = c_ALU_SUB;
          c_FN_AND: w_alu_op = c_ALU_AND;
          c_FN_OR:  w_alu_op = c_ALU_OR;
          c_FN_SLT: w_alu_op = c_ALU_SLT;
          c_FN_SLL: begin w_alu_op = c_ALU_SLL; w_uses_rs = 1'b0; end
          c_FN_SRL: begin w_alu_op = c_ALU_SRL; w_uses_rs = 1'b0; end
          default:  w_ok = 1'b0;
        endcase
      end
      c_OP_ADDI: begin w_alu_src = 1'b1; w_reg_write = 1'b1; end
      c_OP_ANDI: begin w_alu_op = c_ALU_AND; w_alu_src = 1'b1; w_reg_write = 1'b1; w_zext = 1'b1; end
      c_OP_ORI:  begin w_alu_op = c_ALU_OR;  w_alu_src = 1'b1; w_reg_write = 1'b1; w_zext = 1'b1; end
      c_OP_SLTI: begin w_alu_op = c_ALU_SLT; w_alu_src = 1'b1; w_reg_write = 1'b1; end
      c_OP_LUI:  begin w_alu_op = c_ALU_LUI; w_alu_src = 1'b1; w_reg_write = 1'b1; w_uses_rs = 1'b0; end
      c_OP_LW: begin
        w_alu_src    = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
      end
      c_OP_SW: begin w_alu_src = 1'b1; w_mem_write = 1'b1; w_uses_rt = 1'b1; end
      c_OP_BEQ: begin w_alu_op = c_ALU_SUB; w_branch = 1'b1; w_uses_rt = 1'b1; end
      default: w_ok = 1'b0;
    endcase
    // Unsupported words become bubbles and therefore must never request a stall.
    if (!w_ok) begin
      w_uses_rs = 1'b0;
      w_uses_rt = 1'b0;
    end
    if (w_dst == 5'd0) begin
      w_reg_write = 1'b0;
    end
  end

  assign w_imm = w_zext ? {16'h0000, bus.if_instr[15:0]}
                        : {{16{bus.if_instr[15]}}, bus.if_instr[15:0]};

  assign w_stall = bus.if_valid & ~bus.flush & r_valid & r_mem_read & (r_dst != 5'd0) &
                   ((w_uses_rs & (r_dst == w_rs)) | (w_uses_rt & (r_dst == w_rt)));

  assign w_load = bus.if_valid & ~bus.flush & ~w_stall & w_ok;

  // Every field is zeroed on a bubble so a dead EX slot is fully quiet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_pc4        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_dst        <= '0;
      r_shamt      <= '0;
      r_alu_op     <= '0;
      r_alu_src    <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_branch     <= 1'b0;
    end else begin
      r_valid      <= w_load;
      r_rs_data    <= w_load ? bus.rs_data : '0;
      r_rt_data    <= w_load ? bus.rt_data : '0;
      r_imm        <= w_load ? w_imm : '0;
      r_pc4        <= w_load ? bus.if_pc4 : '0;
      r_rs         <= w_load ? w_rs : '0;
      r_rt         <= w_load ? w_rt : '0;
      r_dst        <= w_load ? w_dst : '0;
      r_shamt      <= w_load ? bus.if_instr[10:6] : '0;
      r_alu_op     <= w_load ? w_alu_op : '0;
      r_alu_src    <= w_load & w_alu_src;
      r_mem_read   <= w_load & w_mem_read;
      r_mem_write  <= w_load & w_mem_write;
      r_reg_write  <= w_load & w_reg_write;
      r_mem_to_reg <= w_load & w_mem_to_reg;
      r_branch     <= w_load & w_branch;
    end
  end

  assign bus.rs_addr       = w_rs;
  assign bus.rt_addr       = w_rt;
  assign bus.stall_out     = w_stall;
  assign bus.ex_valid      = r_valid;
  assign bus.ex_rs_data    = r_rs_data;
  assign bus.ex_rt_data    = r_rt_data;
  assign bus.ex_imm        = r_imm;
  assign bus.ex_pc4        = r_pc4;
  assign bus.ex_rs         = r_rs;
  assign bus.ex_rt         = r_rt;
  assign bus.ex_dst        = r_dst;
  assign bus.ex_shamt      = r_shamt;
  assign bus.ex_alu_op     = r_alu_op;
  assign bus.ex_alu_src    = r_alu_src;
  assign bus.ex_mem_read   = r_mem_read;
  assign bus.ex_mem_write  = r_mem_write;
  assign bus.ex_reg_write  = r_reg_write;
  assign bus.ex_mem_to_reg = r_mem_to_reg;
  assign bus.ex_branch     = r_branch;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Directed scoreboard bench for the ID/EX decode stage
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  typedef struct packed {
    logic        v;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [4:0]  sh;
    logic [2:0]  op;
    logic        src;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        m2r;
    logic        br;
  } exp_t;

  logic clk;
  logic reset;
  id_ex_stage_if bus ();

  id_ex_stage u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int          n     = 0;
  logic [31:0] pc    = 32'h0000_0100;
  logic        fix_rsd = 1'b0;
  logic [31:0] fix_val = '0;
  exp_t        sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] sx16(input logic [31:0] ins);
    return {{16{ins[15]}}, ins[15:0]};
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.v   = bus.ex_valid;
    o.rsd = bus.ex_rs_data;
    o.rtd = bus.ex_rt_data;
    o.imm = bus.ex_imm;
    o.pc4 = bus.ex_pc4;
    o.rs  = bus.ex_rs;
    o.rt  = bus.ex_rt;
    o.dst = bus.ex_dst;
    o.sh  = bus.ex_shamt;
    o.op  = bus.ex_alu_op;
    o.src = bus.ex_alu_src;
    o.mr  = bus.ex_mem_read;
    o.mw  = bus.ex_mem_write;
    o.rw  = bus.ex_reg_write;
    o.m2r = bus.ex_mem_to_reg;
    o.br  = bus.ex_branch;
    return o;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, p4, rsd, rtd, input logic fl);
    bus.if_valid = v;
    bus.if_instr = ins;
    bus.if_pc4   = p4;
    bus.rs_data  = rsd;
    bus.rt_data  = rtd;
    bus.flush    = fl;
  endtask

  task automatic chk_stall(input logic e, input string tag);
    #1;
    total++;
    assert (bus.stall_out === e) else begin
      bad++;
      $error("FAIL %s stall: got=%b want=%b", tag, bus.stall_out, e);
    end
  endtask

  task automatic chk_zero(input string tag);
    exp_t o;
    o = observe();
    total++;
    assert (o === exp_t'(0)) else begin
      bad++;
      $error("FAIL %s ex: got=%h want=0", tag, o);
    end
  endtask

  task automatic tick(input string tag);
    exp_t o, e;
    @(posedge clk);
    #1;
    o = observe();
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s scoreboard: got=empty want=entry", tag);
    end else begin
      e = sb.pop_front();
      assert (o === e) else begin
        bad++;
        $error("FAIL %s ex: got=%h want=%h", tag, o, e);
      end
    end
  endtask

  task automatic step(input string tag, input logic [31:0] ins, input logic v, fl, st, ld,
                      input logic [4:0] dst, input logic [31:0] imm, input logic [2:0] op,
                      input logic src, mr, mw, rw, m2r, br);
    exp_t        e;
    logic [31:0] rsd, rtd;
    n++;
    pc  = pc + 32'd4;
    rsd = fix_rsd ? fix_val : 32'h1000_0000 + 32'(n);
    rtd = 32'h2000_0000 + 32'(n * 3);
    fix_rsd = 1'b0;
    drive(v, ins, pc, rsd, rtd, fl);
    chk_stall(st, tag);
    e = '0;
    if (ld) begin
      e.v = 1'b1; e.rsd = rsd; e.rtd = rtd; e.imm = imm; e.pc4 = pc;
      e.rs = ins[25:21]; e.rt = ins[20:16]; e.dst = dst; e.sh = ins[10:6];
      e.op = op; e.src = src; e.mr = mr; e.mw = mw; e.rw = rw; e.m2r = m2r; e.br = br;
    end
    sb.push_back(e);
    tick(tag);
  endtask

  task automatic load(input string tag, input logic [31:0] ins, input logic [4:0] dst,
                      input logic [31:0] imm, input logic [2:0] op,
                      input logic src, mr, mw, rw, m2r, br);
    step(tag, ins, 1'b1, 1'b0, 1'b0, 1'b1, dst, imm, op, src, mr, mw, rw, m2r, br);
  endtask

  task automatic bubble(input string tag, input logic [31:0] ins, input logic v, fl, st);
    step(tag, ins, v, fl, st, 1'b0, 5'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] w_lw2, w_add;
    w_lw2 = itype(6'h23, 5'd1, 5'd2, 16'h0000);
    w_add = rtype(5'd2, 5'd4, 5'd3, 5'd0, 6'h20);

    reset = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    chk_stall(1'b0, "rst_init");
    chk_zero("rst_init");
    #3 reset = 1'b0;

    // decode sweep
    load("addi5", 32'h2001_0005, 5'd1, 32'd5, 3'd0, 1, 0, 0, 1, 0, 0);
    load("add", rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 5'd3, sx16(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20)), 3'd0, 0, 0, 0, 1, 0, 0);
    load("sub", rtype(5'd4, 5'd5, 5'd6, 5'd0, 6'h22), 5'd6, sx16(rtype(5'd4, 5'd5, 5'd6, 5'd0, 6'h22)), 3'd1, 0, 0, 0, 1, 0, 0);
    load("and", rtype(5'd7, 5'd8, 5'd9, 5'd0, 6'h24), 5'd9, sx16(rtype(5'd7, 5'd8, 5'd9, 5'd0, 6'h24)), 3'd2, 0, 0, 0, 1, 0, 0);
    load("or", rtype(5'd10, 5'd11, 5'd12, 5'd0, 6'h25), 5'd12, sx16(rtype(5'd10, 5'd11, 5'd12, 5'd0, 6'h25)), 3'd3, 0, 0, 0, 1, 0, 0);
    load("slt", rtype(5'd13, 5'd14, 5'd15, 5'd0, 6'h2A), 5'd15, sx16(rtype(5'd13, 5'd14, 5'd15, 5'd0, 6'h2A)), 3'd4, 0, 0, 0, 1, 0, 0);
    load("sll", rtype(5'd0, 5'd16, 5'd17, 5'd4, 6'h00), 5'd17, sx16(rtype(5'd0, 5'd16, 5'd17, 5'd4, 6'h00)), 3'd5, 0, 0, 0, 1, 0, 0);
    load("srl", rtype(5'd0, 5'd18, 5'd19, 5'd31, 6'h02), 5'd19, 32'hFFFF_9FC2, 3'd6, 0, 0, 0, 1, 0, 0);
    load("addi_neg", itype(6'h08, 5'd3, 5'd4, 16'h8000), 5'd4, 32'hFFFF_8000, 3'd0, 1, 0, 0, 1, 0, 0);
    load("andi", itype(6'h0C, 5'd5, 5'd6, 16'h8001), 5'd6, 32'h0000_8001, 3'd2, 1, 0, 0, 1, 0, 0);
    load("ori", itype(6'h0D, 5'd7, 5'd8, 16'h8000), 5'd8, 32'h0000_8000, 3'd3, 1, 0, 0, 1, 0, 0);
    load("slti", itype(6'h0A, 5'd9, 5'd10, 16'hFFFE), 5'd10, 32'hFFFF_FFFE, 3'd4, 1, 0, 0, 1, 0, 0);
    load("lui", itype(6'h0F, 5'd0, 5'd11, 16'h8000), 5'd11, 32'hFFFF_8000, 3'd7, 1, 0, 0, 1, 0, 0);
    load("lw", itype(6'h23, 5'd1, 5'd12, 16'h0004), 5'd12, 32'd4, 3'd0, 1, 1, 0, 1, 1, 0);
    load("sw", itype(6'h2B, 5'd13, 5'd14, 16'h0008), 5'd14, 32'd8, 3'd0, 1, 0, 1, 0, 0, 0);
    load("beq", itype(6'h04, 5'd15, 5'd16, 16'hFFFC), 5'd16, 32'hFFFF_FFFC, 3'd1, 0, 0, 0, 0, 0, 1);
    bubble("op3f", 32'hFC00_0000, 1'b1, 1'b0, 1'b0);
    bubble("bad_funct", rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F), 1'b1, 1'b0, 1'b0);
    load("nop_word", 32'h0000_0000, 5'd0, 32'd0, 3'd5, 0, 0, 0, 0, 0, 0);
    load("addi_r0", itype(6'h08, 5'd1, 5'd0, 16'h0007), 5'd0, 32'd7, 3'd0, 1, 0, 0, 0, 0, 0);

    // load-use on rs, then the held add loads
    load("lu_lw", w_lw2, 5'd2, 32'd0, 3'd0, 1, 1, 0, 1, 1, 0);
    bubble("lu_stall", w_add, 1'b1, 1'b0, 1'b1);
    load("lu_add", w_add, 5'd3, sx16(w_add), 3'd0, 0, 0, 0, 1, 0, 0);
    load("lw_r0", itype(6'h23, 5'd1, 5'd0, 16'h0000), 5'd0, 32'd0, 3'd0, 1, 1, 0, 0, 1, 0);
    load("r0_add", rtype(5'd0, 5'd4, 5'd3, 5'd0, 6'h20), 5'd3, sx16(rtype(5'd0, 5'd4, 5'd3, 5'd0, 6'h20)), 3'd0, 0, 0, 0, 1, 0, 0);

    // rt-only consumer stalls; lui does not read rt
    load("lu_lw2", w_lw2, 5'd2, 32'd0, 3'd0, 1, 1, 0, 1, 1, 0);
    bubble("sll_stall", rtype(5'd0, 5'd2, 5'd5, 5'd3, 6'h00), 1'b1, 1'b0, 1'b1);
    load("sll_go", rtype(5'd0, 5'd2, 5'd5, 5'd3, 6'h00), 5'd5, sx16(rtype(5'd0, 5'd2, 5'd5, 5'd3, 6'h00)), 3'd5, 0, 0, 0, 1, 0, 0);
    load("lu_lw3", w_lw2, 5'd2, 32'd0, 3'd0, 1, 1, 0, 1, 1, 0);
    load("lui_nostall", itype(6'h0F, 5'd0, 5'd2, 16'h1234), 5'd2, 32'h0000_1234, 3'd7, 1, 0, 0, 1, 0, 0);

    // flush overrides the hazard
    load("fl_lw", w_lw2, 5'd2, 32'd0, 3'd0, 1, 1, 0, 1, 1, 0);
    bubble("fl_kill", w_add, 1'b1, 1'b1, 1'b0);
    load("fl_next", rtype(5'd8, 5'd9, 5'd7, 5'd0, 6'h25), 5'd7, sx16(rtype(5'd8, 5'd9, 5'd7, 5'd0, 6'h25)), 3'd3, 0, 0, 0, 1, 0, 0);

    // idle cycles, then operand capture
    bubble("idle1", w_add, 1'b0, 1'b0, 1'b0);
    bubble("idle2", w_add, 1'b0, 1'b0, 1'b0);
    fix_rsd = 1'b1;
    fix_val = 32'hDEAD_BEEF;
    load("beef", rtype(5'd6, 5'd7, 5'd8, 5'd0, 6'h20), 5'd8, sx16(rtype(5'd6, 5'd7, 5'd8, 5'd0, 6'h20)), 3'd0, 0, 0, 0, 1, 0, 0);

    // asynchronous reset during a stall
    load("rs_lw", w_lw2, 5'd2, 32'd0, 3'd0, 1, 1, 0, 1, 1, 0);
    drive(1'b1, w_add, pc + 32'd4, 32'd1, 32'd2, 1'b0);
    chk_stall(1'b1, "rst_mid_pre");
    reset = 1'b1;
    chk_stall(1'b0, "rst_mid");
    chk_zero("rst_mid");
    #1 reset = 1'b0;
    load("addi_after", 32'h2001_0005, 5'd1, 32'd5, 3'd0, 1, 0, 0, 1, 0, 0);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_drain: got=%0d want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
